// File: rtl/vhd_sector_ctrl.sv
// Single-sector VHD transfer sequencer between the disk controller and the hps_io sd_* block port.
// Owns a 512x8 sector buffer, tracks the mounted image size and times out stalled sd requests.
module vhd_sector_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned TMO_W          = 21
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        img_present,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_wdata,
  input  logic        buf_we,
  output logic [7:0]  buf_rdata,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_lba,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        img_mounted,
  input  logic [63:0] img_size
);

  // state | meaning
  // IDLE  | waiting for a request, image tracking live
  // REQ   | sd_rd/sd_wr held, waiting for sd_ack, timer running
  // XFER  | hps_io moving bytes, waiting for sd_ack to fall
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic             is_rd;
  logic [TMO_W-1:0] timer;
  logic [31:0]      sector_cnt;
  logic [7:0]       mem [512];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      is_rd       <= 1'b0;
      timer       <= '0;
      sector_cnt  <= '0;
      img_present <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      sd_lba      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (img_mounted) begin
        img_present <= |img_size;
        sector_cnt  <= img_size[40:9];
      end
      case (state)
        IDLE: begin
          if (req_rd && req_wr) begin
            err <= 1'b1;
          end else if (req_rd || req_wr) begin
            if (!img_present || req_lba >= sector_cnt) begin
              err <= 1'b1;
            end else begin
              sd_lba <= req_lba;
              is_rd  <= req_rd;
              busy   <= 1'b1;
              sd_rd  <= req_rd;
              sd_wr  <= req_wr;
              timer  <= '0;
              state  <= REQ;
            end
          end
        end
        REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else if (img_mounted || timer == TMO_LIM) begin
            // a remount invalidates the pending LBA, so it is reported like a timeout
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        XFER: begin
          if (!sd_ack) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sd-side and host-side writes never overlap: host writes are blocked while busy
  always_ff @(posedge clk_sys) begin
    if (state == XFER && is_rd && sd_buff_wr)
      mem[sd_buff_addr] <= sd_buff_dout;
    else if (buf_we && !busy)
      mem[buf_addr] <= buf_wdata;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      buf_rdata   <= '0;
      sd_buff_din <= '0;
    end else begin
      buf_rdata   <= mem[buf_addr];
      sd_buff_din <= mem[sd_buff_addr];
    end
  end

endmodule

// File: tb/tb_vhd_sector_ctrl.sv
// Directed bench for vhd_sector_ctrl: request accept/reject table plus write, read,
// timeout, remount-abort and reset sequences against a small hps_io stand-in.
module tb_vhd_sector_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        req_rd, req_wr;
  logic [31:0] req_lba;
  logic        busy, done, err, img_present;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic        buf_we;
  logic [7:0]  buf_rdata;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_ack, sd_buff_wr;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic        img_mounted;
  logic [63:0] img_size;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rd_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  vhd_sector_ctrl #(.TIMEOUT_CYCLES(100), .TMO_W(21)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .busy(busy), .done(done), .err(err), .img_present(img_present),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .img_mounted(img_mounted), .img_size(img_size)
  );

  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (sd_rd) rd_cnt++;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic mount(input logic [63:0] size);
    img_size    = size;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
  endtask

  task automatic finish_xfer();
    sd_ack = 1'b1;
    tick();
    check1("ack_drop_rd", sd_rd, 1'b0);
    check1("ack_drop_wr", sd_wr, 1'b0);
    check1("xfer_busy", busy, 1'b1);
    sd_ack = 1'b0;
    tick();
    check1("done_pulse", done, 1'b1);
    check1("done_busy_low", busy, 1'b0);
    tick();
    check1("done_one_cycle", done, 1'b0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic        exp_err;
    logic        exp_sdrd;
    logic        exp_sdwr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int d0, e0, r0;
    vecs[0] = '{1'b1, 1'b0, 32'd0,          1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'd2047,       1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'd2048,       1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'd2048,       1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'd3,          1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'd5,          1'b0, 1'b0, 1'b1};

    reset_n = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_lba = '0;
    buf_addr = '0; buf_wdata = '0; buf_we = 1'b0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
    img_mounted = 1'b0; img_size = '0;
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_img_present", img_present, 1'b0);
    check1("rst_sd_rd", sd_rd, 1'b0);
    check1("rst_sd_wr", sd_wr, 1'b0);
    check32("rst_sd_lba", sd_lba, 32'd0);
    check32("rst_buf_rdata", {24'd0, buf_rdata}, 32'd0);
    check32("rst_sd_buff_din", {24'd0, sd_buff_din}, 32'd0);
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    tick();

    // no image mounted
    r0 = rd_cnt;
    req_rd = 1'b1; req_lba = 32'd0;
    tick();
    req_rd = 1'b0;
    check1("noimg_err", err, 1'b1);
    check1("noimg_busy", busy, 1'b0);
    tick();
    check1("noimg_err_pulse", err, 1'b0);
    check32("noimg_sd_rd_never", 32'(rd_cnt - r0), 32'd0);

    mount(64'd0);
    check1("mount0_absent", img_present, 1'b0);
    mount(64'd1 << 20);
    check1("mount_present", img_present, 1'b1);

    for (int i = 0; i < 7; i++) begin
      req_rd = vecs[i].rd; req_wr = vecs[i].wr; req_lba = vecs[i].lba;
      tick();
      req_rd = 1'b0; req_wr = 1'b0;
      check1($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check1($sformatf("vec%0d_busy", i), busy, vecs[i].exp_sdrd | vecs[i].exp_sdwr);
      check1($sformatf("vec%0d_sd_rd", i), sd_rd, vecs[i].exp_sdrd);
      check1($sformatf("vec%0d_sd_wr", i), sd_wr, vecs[i].exp_sdwr);
      tick();
      check1($sformatf("vec%0d_err_pulse", i), err, 1'b0);
      if (vecs[i].exp_sdrd | vecs[i].exp_sdwr) begin
        check32($sformatf("vec%0d_sd_lba", i), sd_lba, vecs[i].lba);
        finish_xfer();
      end else begin
        check1($sformatf("vec%0d_no_rd", i), sd_rd, 1'b0);
      end
    end

    // host fills buffer, then sector write to lba 5
    for (int a = 0; a < 512; a++) begin
      buf_addr = a[8:0]; buf_wdata = a[7:0]; buf_we = 1'b1;
      tick();
    end
    buf_we = 1'b0;
    buf_addr = 9'd300;
    tick();
    check32("host_rdback", {24'd0, buf_rdata}, 32'h2C);
    req_wr = 1'b1; req_lba = 32'd5;
    tick();
    req_wr = 1'b0;
    check1("wr_sd_wr", sd_wr, 1'b1);
    check32("wr_sd_lba", sd_lba, 32'd5);
    buf_addr = 9'd10; buf_wdata = 8'hEE; buf_we = 1'b1;
    repeat (3) tick();
    buf_we = 1'b0;
    check1("wr_hold", sd_wr, 1'b1);
    sd_ack = 1'b1;
    tick();
    check1("wr_ack_drop", sd_wr, 1'b0);
    for (int a = 0; a < 512; a++) begin
      sd_buff_addr = a[8:0];
      tick();
      check32($sformatf("wr_din_%0d", a), {24'd0, sd_buff_din}, {24'd0, a[7:0]});
    end
    sd_ack = 1'b0;
    tick();
    check1("wr_done", done, 1'b1);
    tick();
    check1("wr_done_pulse", done, 1'b0);
    buf_addr = 9'd10;
    tick();
    check32("we_blocked_busy", {24'd0, buf_rdata}, 32'h0A);

    // sector read from last lba, with extra requests while busy
    d0 = done_cnt; e0 = err_cnt;
    req_rd = 1'b1; req_lba = 32'd2047;
    tick();
    req_rd = 1'b0;
    check1("rd_sd_rd", sd_rd, 1'b1);
    tick();
    req_rd = 1'b1; req_lba = 32'd0;
    tick();
    req_rd = 1'b0;
    check32("rd_lba_stable", sd_lba, 32'd2047);
    sd_ack = 1'b1;
    tick();
    for (int a = 0; a < 512; a++) begin
      sd_buff_wr = 1'b1; sd_buff_addr = a[8:0]; sd_buff_dout = 8'hA5 ^ a[7:0];
      req_wr = (a == 100);
      tick();
    end
    sd_buff_wr = 1'b0; req_wr = 1'b0; sd_ack = 1'b0;
    repeat (4) tick();
    check32("rd_single_done", 32'(done_cnt - d0), 32'd1);
    check32("rd_no_err", 32'(err_cnt - e0), 32'd0);
    check1("rd_idle_busy", busy, 1'b0);
    for (int a = 0; a < 512; a++) begin
      buf_addr = a[8:0];
      tick();
      check32($sformatf("rd_buf_%0d", a), {24'd0, buf_rdata}, {24'd0, 8'hA5 ^ a[7:0]});
    end

    // ack never returns
    req_rd = 1'b1; req_lba = 32'd1;
    tick();
    req_rd = 1'b0;
    n = 0;
    r0 = 0;
    while (!err && n < 200) begin
      if (!sd_rd) r0++;
      tick();
      n++;
    end
    check32("tmo_cycles", 32'(n), 32'd101);
    check32("tmo_rd_held", 32'(r0), 32'd0);
    check1("tmo_sd_rd", sd_rd, 1'b0);
    check1("tmo_busy", busy, 1'b0);
    tick();
    check1("tmo_err_pulse", err, 1'b0);

    // remount while waiting for ack
    req_rd = 1'b1; req_lba = 32'd1;
    tick();
    req_rd = 1'b0;
    tick();
    mount(64'd1 << 20);
    check1("abort_err", err, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_sd_rd", sd_rd, 1'b0);
    check1("abort_present", img_present, 1'b1);

    // reset while request pending
    req_rd = 1'b1; req_lba = 32'd3;
    tick();
    req_rd = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check1("rstreq_sd_rd", sd_rd, 1'b0);
    check1("rstreq_busy", busy, 1'b0);
    tick();
    reset_n = 1'b1;
    mount(64'd1 << 20);

    // reset mid-transfer, then a normal read
    req_rd = 1'b1; req_lba = 32'd3;
    tick();
    req_rd = 1'b0;
    sd_ack = 1'b1;
    tick();
    sd_buff_wr = 1'b1; sd_buff_addr = 9'd7; sd_buff_dout = 8'h55;
    tick();
    sd_buff_wr = 1'b0;
    #2;
    reset_n = 1'b0;
    sd_ack = 1'b0;
    #1;
    check1("rstx_busy", busy, 1'b0);
    check32("rstx_sd_lba", sd_lba, 32'd0);
    check1("rstx_present", img_present, 1'b0);
    check32("rstx_din", {24'd0, sd_buff_din}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    mount(64'd1 << 20);
    req_rd = 1'b1; req_lba = 32'd3;
    tick();
    req_rd = 1'b0;
    check1("post_rst_sd_rd", sd_rd, 1'b1);
    check32("post_rst_lba", sd_lba, 32'd3);
    finish_xfer();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
